// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse decoder and the future encoder:
//   state_t       - controller states (IDLE, MARK, SPACE, WAIT_WORD)
//   INVALID_CODE  - char_code reported for overflowed or unknown patterns
//   LETTER_BASE   - code of 'A'; letters occupy LETTER_BASE .. LETTER_BASE+25
//   DIGIT_BASE    - code of '0'; digits occupy DIGIT_BASE .. DIGIT_BASE+9
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MARK      = 2'd1,
        SPACE     = 2'd2,
        WAIT_WORD = 2'd3
    } state_t;

    localparam logic [5:0] INVALID_CODE = 6'd63;
    localparam logic [5:0] LETTER_BASE  = 6'd0;
    localparam logic [5:0] DIGIT_BASE   = 6'd26;

endpackage

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational Morse pattern lookup.
//   sym_len  [2:0] in  - number of symbols in the pattern (1..5)
//   sym_bits [4:0] in  - symbols, newest in bit 0, dash = 1, unused bits 0
//   code     [5:0] out - 0-25 = A-Z, 26-35 = 0-9, INVALID_CODE otherwise
// -----------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] sym_len,
    input  logic [4:0] sym_bits,
    output logic [5:0] code
);

    always_comb begin
        // The first symbol sent sits in bit sym_len-1, the last in bit 0.
        case ({sym_len, sym_bits})
            {3'd2, 5'b00001}: code = LETTER_BASE + 6'd0;   // A .-
            {3'd4, 5'b01000}: code = LETTER_BASE + 6'd1;   // B -...
            {3'd4, 5'b01010}: code = LETTER_BASE + 6'd2;   // C -.-.
            {3'd3, 5'b00100}: code = LETTER_BASE + 6'd3;   // D -..
            {3'd1, 5'b00000}: code = LETTER_BASE + 6'd4;   // E .
            {3'd4, 5'b00010}: code = LETTER_BASE + 6'd5;   // F ..-.
            {3'd3, 5'b00110}: code = LETTER_BASE + 6'd6;   // G --.
            {3'd4, 5'b00000}: code = LETTER_BASE + 6'd7;   // H ....
            {3'd2, 5'b00000}: code = LETTER_BASE + 6'd8;   // I ..
            {3'd4, 5'b00111}: code = LETTER_BASE + 6'd9;   // J .---
            {3'd3, 5'b00101}: code = LETTER_BASE + 6'd10;  // K -.-
            {3'd4, 5'b00100}: code = LETTER_BASE + 6'd11;  // L .-..
            {3'd2, 5'b00011}: code = LETTER_BASE + 6'd12;  // M --
            {3'd2, 5'b00010}: code = LETTER_BASE + 6'd13;  // N -.
            {3'd3, 5'b00111}: code = LETTER_BASE + 6'd14;  // O ---
            {3'd4, 5'b00110}: code = LETTER_BASE + 6'd15;  // P .--.
            {3'd4, 5'b01101}: code = LETTER_BASE + 6'd16;  // Q --.-
            {3'd3, 5'b00010}: code = LETTER_BASE + 6'd17;  // R .-.
            {3'd3, 5'b00000}: code = LETTER_BASE + 6'd18;  // S ...
            {3'd1, 5'b00001}: code = LETTER_BASE + 6'd19;  // T -
            {3'd3, 5'b00001}: code = LETTER_BASE + 6'd20;  // U ..-
            {3'd4, 5'b00001}: code = LETTER_BASE + 6'd21;  // V ...-
            {3'd3, 5'b00011}: code = LETTER_BASE + 6'd22;  // W .--
            {3'd4, 5'b01001}: code = LETTER_BASE + 6'd23;  // X -..-
            {3'd4, 5'b01011}: code = LETTER_BASE + 6'd24;  // Y -.--
            {3'd4, 5'b01100}: code = LETTER_BASE + 6'd25;  // Z --..
            {3'd5, 5'b11111}: code = DIGIT_BASE + 6'd0;    // 0 -----
            {3'd5, 5'b01111}: code = DIGIT_BASE + 6'd1;    // 1 .----
            {3'd5, 5'b00111}: code = DIGIT_BASE + 6'd2;    // 2 ..---
            {3'd5, 5'b00011}: code = DIGIT_BASE + 6'd3;    // 3 ...--
            {3'd5, 5'b00001}: code = DIGIT_BASE + 6'd4;    // 4 ....-
            {3'd5, 5'b00000}: code = DIGIT_BASE + 6'd5;    // 5 .....
            {3'd5, 5'b10000}: code = DIGIT_BASE + 6'd6;    // 6 -....
            {3'd5, 5'b11000}: code = DIGIT_BASE + 6'd7;    // 7 --...
            {3'd5, 5'b11100}: code = DIGIT_BASE + 6'd8;    // 8 ---..
            {3'd5, 5'b11110}: code = DIGIT_BASE + 6'd9;    // 9 ----.
            default:          code = INVALID_CODE;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Decodes a keyed Morse stream into letter/digit codes and word boundaries.
// Timing is measured in units supplied by unit_tick.
//   clk        in  - single clock, rising edge
//   reset      in  - asynchronous, active-high
//   unit_tick  in  - one-clk pulse per Morse unit
//   key_in     in  - debounced synchronous key level, 1 = key down
//   char_code  out - decoded code (0-25 A-Z, 26-35 0-9, 63 invalid), held
//   char_valid out - one-clk pulse qualifying char_code
//   word_valid out - one-clk pulse at each word gap
//   busy       out - high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DASH_MIN   = 2,
    parameter int LETTER_GAP = 2,
    parameter int WORD_GAP   = 5,
    parameter int MAX_SYM    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       unit_tick,
    input  logic       key_in,
    output logic [5:0] char_code,
    output logic       char_valid,
    output logic       word_valid,
    output logic       busy
);

    localparam logic [3:0] DASH_MIN_U   = 4'(DASH_MIN);
    localparam logic [3:0] LETTER_GAP_U = 4'(LETTER_GAP);
    localparam logic [3:0] LETTER_LAST  = 4'(LETTER_GAP - 1);
    localparam logic [3:0] WORD_LAST    = 4'(WORD_GAP - 1);
    localparam logic [2:0] MAX_LEN      = 3'(MAX_SYM);

    state_t     state;
    state_t     state_next;
    logic       key_in_d;
    logic       rise;
    logic       fall;
    logic [3:0] unit_count;
    logic [4:0] sym_bits;
    logic [2:0] sym_len;
    logic       overflow;
    logic       is_dash;
    logic       start_letter;
    logic       append_sym;
    logic       emit_char;
    logic       emit_word;
    logic [5:0] lut_code;

    assign rise = key_in & ~key_in_d;
    assign fall = ~key_in & key_in_d;

    // Uses the count registered before this cycle, so a tick landing on the
    // release edge does not lengthen the mark.
    assign is_dash = (unit_count >= DASH_MIN_U);

    morse_lut u_lut (
        .sym_len  (sym_len),
        .sym_bits (sym_bits),
        .code     (lut_code)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        start_letter = 1'b0;
        append_sym   = 1'b0;
        emit_char    = 1'b0;
        emit_word    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    start_letter = 1'b1;
                    state_next   = MARK;
                end
            end
            MARK: begin
                if (fall) begin
                    append_sym = 1'b1;
                    state_next = SPACE;
                end
            end
            SPACE: begin
                // A new key-down wins over a coincident letter-gap tick.
                if (rise) begin
                    state_next = MARK;
                end else if (unit_tick && unit_count == LETTER_LAST) begin
                    emit_char  = 1'b1;
                    state_next = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                if (rise) begin
                    start_letter = 1'b1;
                    state_next   = MARK;
                end else if (unit_tick && unit_count == WORD_LAST) begin
                    emit_word  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_in_d   <= 1'b0;
            unit_count <= 4'd0;
            sym_bits   <= 5'd0;
            sym_len    <= 3'd0;
            overflow   <= 1'b0;
            char_code  <= 6'd0;
            char_valid <= 1'b0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            key_in_d   <= key_in;
            char_valid <= emit_char;
            word_valid <= emit_word;
            busy       <= (state_next != IDLE);

            // The count restarts on each transition, except that WAIT_WORD
            // carries on from LETTER_GAP so it measures units since release.
            if (state_next != state) begin
                unit_count <= (state_next == WAIT_WORD) ? LETTER_GAP_U : 4'd0;
            end else if (unit_tick && state != IDLE && unit_count != 4'hF) begin
                unit_count <= unit_count + 4'd1;
            end

            if (start_letter) begin
                sym_bits <= 5'd0;
                sym_len  <= 3'd0;
                overflow <= 1'b0;
            end else if (append_sym) begin
                if (sym_len == MAX_LEN) begin
                    overflow <= 1'b1;
                end else begin
                    sym_bits <= {sym_bits[3:0], is_dash};
                    sym_len  <= sym_len + 3'd1;
                end
            end

            if (emit_char) begin
                char_code <= overflow ? INVALID_CODE : lut_code;
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
// Scoreboard bench: the stimulus side describes traffic as marks and gaps in
// units, derives the expected letters/words from Morse rules and pushes them
// (with the time they must appear) into a queue; an independent monitor pops
// and compares whenever char_valid or word_valid is seen.
// -----------------------------------------------------------------------------
module tb_morse_decoder;
    import morse_pkg::*;

    localparam int T          = 4;   // clocks per unit
    localparam int CLK_PERIOD = 10;
    localparam int DASH_MIN   = 2;
    localparam int LETTER_GAP = 2;
    localparam int WORD_GAP   = 5;
    localparam int MAX_SYM    = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       unit_tick;
    logic       key_in;
    logic [5:0] char_code;
    logic       char_valid;
    logic       word_valid;
    logic       busy;

    morse_decoder #(
        .DASH_MIN   (DASH_MIN),
        .LETTER_GAP (LETTER_GAP),
        .WORD_GAP   (WORD_GAP),
        .MAX_SYM    (MAX_SYM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .unit_tick  (unit_tick),
        .key_in     (key_in),
        .char_code  (char_code),
        .char_valid (char_valid),
        .word_valid (word_valid),
        .busy       (busy)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    typedef struct {
        bit is_word;
        int code;
        int due;
    } exp_t;

    exp_t  exp_q[$];
    int    checks         = 0;
    int    failures       = 0;
    int    phase          = 2;   // tick phase of the next step; tick at phase 0
    int    last_step_time = 0;
    string cur_pat        = "";

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int model_code(input string pat);
        if (pat.len() > MAX_SYM) return int'(INVALID_CODE);
        foreach (morse_tab[i]) begin
            if (morse_tab[i] == pat) return i;
        end
        return int'(INVALID_CODE);
    endfunction

    // Offset (in steps from the next one) of the nth unit tick.
    function automatic int nth_tick_step(input int nth);
        int seen;
        seen = 0;
        for (int k = 0; k < 1000; k++) begin
            if ((phase + k) % T == 0) begin
                seen++;
                if (seen == nth) return k;
            end
        end
        return -1;
    endfunction

    // One clock of stimulus: key level plus the free-running unit tick.
    task automatic step(input logic k);
        @(negedge clk);
        key_in         = k;
        unit_tick      = (phase == 0);
        phase          = (phase + 1) % T;
        last_step_time = int'($time);
    endtask

    task automatic hold_steps(input logic k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask

    task automatic send_mark(input int units);
        hold_steps(1'b1, units * T);
        if (units >= DASH_MIN) cur_pat = {cur_pat, "-"};
        else                   cur_pat = {cur_pat, "."};
    endtask

    // A gap of LETTER_GAP units or more closes the letter; WORD_GAP or more
    // also closes the word. Each pulse is due one clk after its unit tick.
    task automatic send_gap(input int units);
        exp_t e;
        if (cur_pat.len() != 0 && units >= LETTER_GAP) begin
            e.is_word = 1'b0;
            e.code    = model_code(cur_pat);
            e.due     = last_step_time + CLK_PERIOD * (nth_tick_step(LETTER_GAP) + 2);
            exp_q.push_back(e);
            if (units >= WORD_GAP) begin
                e.is_word = 1'b1;
                e.due     = last_step_time + CLK_PERIOD * (nth_tick_step(WORD_GAP) + 2);
                exp_q.push_back(e);
            end
            cur_pat = "";
        end
        hold_steps(1'b0, units * T);
    endtask

    task automatic send_letter(input string pat, input int gap);
        for (int i = 0; i < pat.len(); i++) begin
            send_mark((pat[i] == "-") ? 3 : 1);
            if (i < pat.len() - 1) send_gap(1);
        end
        send_gap(gap);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            if (char_valid && word_valid) check("both_valid", 1, 0);
            if (char_valid || word_valid) begin
                if (exp_q.size() == 0) begin
                    check(char_valid ? "unexpected_char" : "unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", int'(word_valid), int'(e.is_word));
                    check("pulse_time", int'($time), e.due);
                    if (word_valid) check("code_held_at_word", int'(char_code), e.code);
                    else            check("char_code", int'(char_code), e.code);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        key_in    = 1'b0;
        unit_tick = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("reset_char_code", int'(char_code), 0);
        check("reset_char_valid", int'(char_valid), 0);
        check("reset_word_valid", int'(word_valid), 0);
        check("reset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // A: 1 down, 1 up, 3 down, 2 up.
        send_mark(1);
        check("busy_in_mark", int'(busy), 1);
        send_gap(1);
        send_mark(3);
        send_gap(2);

        // O followed by a word gap; controller must be idle afterwards.
        send_letter("---", 5);
        check("busy_after_word", int'(busy), 0);

        send_letter("......", 2);   // too many symbols -> invalid
        send_letter(".....", 3);    // digit 5
        send_letter("-----", 6);    // digit 0

        // Very long mark: counter saturates, still a dash (T).
        send_mark(17);
        send_gap(7);

        // Rise coincides with the tick that would close the letter: the next
        // mark joins the same letter. "." + "." + "-" = U.
        send_mark(1);
        hold_steps(1'b0, 2 * T - 2);   // one tick seen, next step carries a tick
        hold_steps(1'b1, T + 2);       // one tick after the rise -> dot
        cur_pat = {cur_pat, "."};
        send_gap(1);
        send_mark(3);
        send_gap(2);

        // Reset during a dash: outputs clear at once, partial letter dropped.
        hold_steps(1'b1, 6);
        cur_pat = "";
        step(1'b1);
        #1 reset = 1'b1;
        #1;
        check("async_char_code", int'(char_code), 0);
        check("async_char_valid", int'(char_valid), 0);
        check("async_word_valid", int'(word_valid), 0);
        check("async_busy", int'(busy), 0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        reset = 1'b0;                  // key still down: first rise is seen
        hold_steps(1'b1, 10);          // three units after release -> dash
        cur_pat = {cur_pat, "-"};
        send_gap(1);
        send_mark(1);
        send_gap(2);                   // N

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 1) send_mark($urandom_range(DASH_MIN, 4));
                else                           send_mark(1);
                if (i < len - 1) send_gap(1);
            end
            send_gap($urandom_range(LETTER_GAP, WORD_GAP + 2));
        end

        hold_steps(1'b0, 12 * T);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL provide parameter DASH_MIN, default 2: key-down length, in units, at or above which a mark is a dash.
REQ-002 SHALL provide parameter LETTER_GAP, default 2: key-up length, in units, that ends a letter.
REQ-003 SHALL provide parameter WORD_GAP, default 5: key-up length, in units since the last release, that ends a word.
REQ-004 SHALL provide parameter MAX_SYM, default 5: maximum number of symbols in a valid letter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port unit_tick, input, 1 bit: one-clk pulse per Morse unit, from the clock divider.
REQ-008 SHALL have port key_in, input, 1 bit: debounced, synchronous key level; 1 means key down.
REQ-009 SHALL have port char_code, output, 6 bits: decoded letter (0-25 = A-Z, 26-35 = 0-9, 63 = invalid).
REQ-010 SHALL have port char_valid, output, 1 bit: one-clk pulse that qualifies char_code.
REQ-011 SHALL have port word_valid, output, 1 bit: one-clk pulse at each word gap.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, MARK, SPACE and WAIT_WORD, with all outputs registered.
REQ-014 SHALL keep key_in_d (key_in delayed one clk); a rise is key_in & ~key_in_d and a fall is ~key_in & key_in_d.
REQ-015 SHALL keep a 4-bit unit counter that increments on unit_tick and saturates at 15.
REQ-016 SHALL clear the unit counter on every state transition.
REQ-017 SHALL, on a rise in IDLE or WAIT_WORD, clear sym_bits[4:0], sym_len and the overflow flag, then enter MARK.
REQ-018 SHALL, on a fall in MARK, classify the mark as a dot (counter < DASH_MIN) or a dash (counter >= DASH_MIN), then enter SPACE.
REQ-019 SHALL classify using the counter value from before the current cycle, ignoring a unit_tick that coincides with the fall.
REQ-020 SHALL classify a fall with the counter at 0 as a dot.
REQ-021 SHALL append each symbol by shifting sym_bits left and writing the new symbol into bit 0 (dash = 1), and SHALL increment sym_len.
REQ-022 SHALL set the overflow flag, and leave sym_bits and sym_len unchanged, when a symbol arrives with sym_len == MAX_SYM.
REQ-023 SHALL, on a rise in SPACE, return to MARK (same letter).
REQ-024 SHALL give a rise priority over a unit_tick that coincides with it in SPACE.
REQ-025 SHALL, in SPACE, when a unit_tick brings the counter to LETTER_GAP, pulse char_valid on the next clk and enter WAIT_WORD.
REQ-026 SHALL drive char_code with the lookup result, or 63 when overflow is set or the pattern is not in the table.
REQ-027 SHALL hold char_code until the next char_valid.
REQ-028 SHALL keep counting units in WAIT_WORD, continuing from LETTER_GAP.
REQ-029 SHALL pulse word_valid once on the next clk when the counter reaches WORD_GAP in WAIT_WORD, then enter IDLE.
REQ-030 SHALL ignore unit_tick in IDLE and never pulse char_valid or word_valid from IDLE.
REQ-031 SHALL never assert char_valid and word_valid in the same clk.
REQ-032 SHALL, when key_in is high during reset release, treat key_in_d as having reset to 0, so the first rise is seen and MARK is entered.

Reset
REQ-033 SHALL, on reset, force state = IDLE; counter, sym_bits, sym_len, overflow, key_in_d, char_code, char_valid, word_valid and busy = 0, immediately and regardless of clk.
REQ-034 SHALL discard any partial letter when reset is asserted mid-operation, with no pulse after release.

Structure
REQ-035 SHALL place the state encoding, INVALID_CODE = 63 and the code-base constants (LETTER_BASE = 0, DIGIT_BASE = 26) in shared package morse_pkg.
REQ-036 SHALL implement the lookup table as combinational sub-module morse_lut (inputs sym_len, sym_bits; output code[5:0]), shared with the future encoder.

Verification
REQ-037 SHALL verify: key down 1 unit, up 1, down 3, up 2 -> one char_valid pulse with char_code = 0 (A).
REQ-038 SHALL verify: three 3-unit marks (O), then key up 5 units -> char_code = 14, then exactly one word_valid pulse 5 units after the last release, and busy = 0 afterwards.
REQ-039 SHALL verify: six 1-unit dots, then a letter gap -> char_code = 63 with a single char_valid.
REQ-040 SHALL verify: five dots -> char_code = 31 (digit 5), and five dashes -> char_code = 26 (digit 0).
REQ-041 SHALL verify: a rise in the same clk as the unit_tick that would make the SPACE counter reach LETTER_GAP -> no char_valid, and the following marks are appended to the same letter.
REQ-042 SHALL verify: reset asserted for 3 clk in the middle of a dash -> all outputs 0 asynchronously; after release, "-." decodes to char_code = 13 (N).
